// File: rtl/mcs4_pkg.sv
// Shared MCS-4 core types: address, instruction phase and PC-operation encodings.
package mcs4;

    localparam int ADDR_BITS    = 12;
    localparam int STACK_LEVELS = 4;

    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JMP,
        PC_JMP_PAGE,
        PC_CALL,
        PC_RET
    } pc_op_t;

endpackage

// File: rtl/i4004_pc_stack_ctl.sv
// i4004 program counter and 4-level address stack; applies one PC op per instruction cycle.
// Optional sticky overflow/underflow flags via macro I4004_PC_STACK_ERR_EN.
module i4004_pc_stack_ctl
    import mcs4::*;
#(
    parameter int STACK_DEPTH = STACK_LEVELS,
    parameter int ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  instr_cyc_t        icyc,
    input  pc_op_t            pc_op,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        addr_nib,
    output logic [1:0]        depth
`ifdef I4004_PC_STACK_ERR_EN
    ,
    output logic [1:0]        stack_err
`endif
);

    localparam int         PTR_W     = $clog2(STACK_DEPTH);
    localparam logic [1:0] DEPTH_MAX = 2'd3;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_up;
    logic [PTR_W-1:0]  ptr_dn;
    logic [ADDR_W-1:0] inc;
    instr_cyc_t        icyc_q;
    logic              armed;
    logic              commit;

    function automatic logic [1:0] depth_push(input logic [1:0] d);
        return (d == DEPTH_MAX) ? d : d + 2'd1;
    endfunction

    function automatic logic [1:0] depth_pop(input logic [1:0] d);
        return (d == 2'd0) ? d : d - 2'd1;
    endfunction

    function automatic logic [3:0] nib_sel(input instr_cyc_t c, input logic [ADDR_W-1:0] a);
        case (c)
            A1:      return a[3:0];
            A2:      return a[7:4];
            A3:      return a[11:8];
            default: return 4'h0;
        endcase
    endfunction

    assign pc     = stack[ptr];
    assign inc    = pc + ADDR_W'(1);
    assign ptr_up = ptr + PTR_W'(1);
    assign ptr_dn = ptr - PTR_W'(1);

    // A reset mid-instruction leaves 'armed' low until the next A1, so the
    // interrupted instruction's op can never commit.
    assign commit = armed && (icyc == X3) && (icyc_q != X3);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
            ptr      <= '0;
            depth    <= 2'd0;
            addr_nib <= 4'h0;
            icyc_q   <= A1;
            armed    <= 1'b0;
        end else begin
            icyc_q   <= icyc;
            addr_nib <= nib_sel(icyc, pc);
            if (icyc == A1) armed <= 1'b1;
            if (commit) begin
                case (pc_op)
                    PC_HOLD: begin
                    end
                    PC_JMP: stack[ptr] <= target;
                    PC_JMP_PAGE: stack[ptr] <= {inc[ADDR_W-1:8], target[7:0]};
                    PC_CALL: begin
                        stack[ptr]    <= inc;
                        stack[ptr_up] <= target;
                        ptr           <= ptr_up;
                        depth         <= depth_push(depth);
                    end
                    PC_RET: begin
                        ptr   <= ptr_dn;
                        depth <= depth_pop(depth);
                    end
                    default: stack[ptr] <= inc;
                endcase
            end
        end
    end

`ifdef I4004_PC_STACK_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err <= 2'b00;
        end else if (commit) begin
            if (pc_op == PC_CALL && depth == DEPTH_MAX) stack_err[0] <= 1'b1;
            if (pc_op == PC_RET && depth == 2'd0) stack_err[1] <= 1'b1;
        end
    end
`endif

endmodule
